// File: rtl/logic_op_pkg.sv
// Shared types and constants for the logic op sequencer.
// Gate op indices, state encoding and op count.
package logic_op_pkg;

   localparam int NUM_OPS = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NOT  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;
   localparam logic [2:0] OP_LAST = OP_XNOR;

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Operand/result handshake bundle for the logic op sequencer.
// master = host driver, slave = sequencer.
interface logic_op_sequencer_if #(
   parameter int WIDTH = 4
);
   import logic_op_pkg::*;

   logic                       in_valid;
   logic                       in_ready;
   logic [WIDTH-1:0]           a;
   logic [WIDTH-1:0]           b;
   logic [NUM_OPS-1:0]         op_mask;
   logic                       out_valid;
   logic                       out_ready;
   logic [NUM_OPS*WIDTH-1:0]   result;
   logic                       busy;
   logic [2:0]                 op_idx;

   modport master (
      output in_valid, a, b, op_mask, out_ready,
      input  in_ready, out_valid, result, busy, op_idx
   );

   modport slave (
      input  in_valid, a, b, op_mask, out_ready,
      output in_ready, out_valid, result, busy, op_idx
   );

endinterface

// File: rtl/logic_op_sequencer_logic_unit.sv
// Shared combinational gate unit: one of seven bitwise functions.
// Unused op code 7 yields zero.
module logic_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y
);

   // select the gate function for the current op
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOT:  y = ~a;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_op_sequencer.sv
// Steps one shared gate unit through all seven ops per request,
// packing enabled results into a single word.
module logic_op_sequencer
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   logic_op_sequencer_if.slave  bus
);

   state_t                     state;
   state_t                     state_nxt;
   logic [WIDTH-1:0]           a_q;
   logic [WIDTH-1:0]           b_q;
   logic [NUM_OPS-1:0]         mask_q;
   logic [2:0]                 idx_q;
   logic [NUM_OPS*WIDTH-1:0]   res_q;
   logic [WIDTH-1:0]           y;
   logic                       accept;
   logic                       last_op;

   assign accept  = (state == IDLE) && bus.in_valid;
   assign last_op = (idx_q == OP_LAST);

   logic_unit #(.WIDTH(WIDTH)) u_unit (
      .a  (a_q),
      .b  (b_q),
      .op (idx_q),
      .y  (y)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state: fixed seven-cycle sweep, then hold until consumed
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = bus.in_valid ? EVAL : IDLE;
         EVAL:    state_nxt = last_op ? DONE : EVAL;
         DONE:    state_nxt = bus.out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // handshake and debug outputs decoded from state
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.busy      = (state == EVAL) || (state == DONE);
      bus.op_idx    = (state == EVAL) ? idx_q : 3'd0;
   end

   // operand capture, op counter and result packing
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         mask_q <= '0;
         idx_q  <= '0;
         res_q  <= '0;
      end else if (accept) begin
         a_q    <= bus.a;
         b_q    <= bus.b;
         mask_q <= bus.op_mask;
         idx_q  <= '0;
         res_q  <= '0;
      end else if (state == EVAL) begin
         if (mask_q[idx_q])
            res_q[int'(idx_q)*WIDTH +: WIDTH] <= y;
         idx_q <= last_op ? 3'd0 : idx_q + 3'd1;
      end
   end

   assign bus.result = res_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Scoreboard bench for logic_op_sequencer: directed scenarios
// plus randomized ops against a behavioural gate model.
module tb_logic_op_sequencer;

   localparam int W = 4;
   localparam int RW = 7 * W;

   typedef struct {
      logic [RW-1:0] exp;
      int            acc;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   item_t q[$];
   bit   prev_valid = 1'b0;
   int   ecount = 0;

   logic_op_sequencer_if #(.WIDTH(W)) bus ();

   logic_op_sequencer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input bit ok,
                      input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)",
                  name, act, req, cyc);
      end
   endtask

   function automatic logic [RW-1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [6:0] m);
      logic [W-1:0] r [7];
      logic [RW-1:0] o;
      r[0] = a & b;
      r[1] = a | b;
      r[2] = ~a;
      r[3] = ~(a & b);
      r[4] = ~(a | b);
      r[5] = a ^ b;
      r[6] = ~(a ^ b);
      o = '0;
      for (int k = 0; k < 7; k++)
         if (m[k]) o[k*W +: W] = r[k];
      return o;
   endfunction

   // monitor: op_idx sweep, latency, result scoreboard
   always @(negedge clk) begin
      if (rst) begin
         ecount = 0;
         prev_valid = 1'b0;
      end else begin
         if (bus.busy && !bus.out_valid) begin
            chk("op_idx_seq", bus.op_idx == 3'(ecount),
                32'(bus.op_idx), 32'(ecount));
            ecount++;
         end else if (!bus.busy) begin
            chk("op_idx_idle", bus.op_idx == 3'd0,
                32'(bus.op_idx), 32'd0);
         end
         if (bus.out_valid && !prev_valid) begin
            chk("eval_cycles", ecount == 7, 32'(ecount), 32'd7);
            ecount = 0;
            if (q.size() == 0)
               chk("unexpected_valid", 1'b0, 32'd1, 32'd0);
            else
               chk("latency", cyc - q[0].acc == 8,
                   32'(cyc - q[0].acc), 32'd8);
         end
         if (bus.out_valid && bus.out_ready && q.size() != 0) begin
            item_t it;
            it = q.pop_front();
            chk("result", bus.result == it.exp,
                32'(bus.result), 32'(it.exp));
         end
         prev_valid = bus.out_valid;
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [6:0] m, input logic [RW-1:0] e,
                       input bit hold, output int acc);
      bit got;
      item_t it;
      got = 1'b0;
      acc = 0;
      @(posedge clk);
      #1;
      bus.a = a;
      bus.b = b;
      bus.op_mask = m;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("accept_timeout", 1'b0, 32'd0, 32'd1);
      end else begin
         acc = cyc;
         it.exp = e;
         it.acc = cyc;
         q.push_back(it);
      end
      @(posedge clk);
      #1;
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit bp);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (q.size() == 0 && bus.in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (bp) bus.out_ready = 1'($urandom_range(0, 1));
      end
      bus.out_ready = 1'b1;
      if (!ok) begin
         chk("done_timeout", 1'b0, 32'd0, 32'd1);
         q.delete();
      end
   endtask

   localparam logic [RW-1:0] E_FULL =
      {4'b1001, 4'b0110, 4'b0001, 4'b0111, 4'b0011, 4'b1110, 4'b1000};
   localparam logic [RW-1:0] E_PART =
      {4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
   localparam logic [RW-1:0] E_ZF =
      {4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000};

   initial begin
      int acc1;
      int acc2;
      logic [RW-1:0] held;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [6:0] rm;
      bit found;

      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.op_mask = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready == 1'b1, 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", bus.out_valid == 1'b0, 32'(bus.out_valid), 32'd0);
      chk("rst_busy", bus.busy == 1'b0, 32'(bus.busy), 32'd0);
      chk("rst_result", bus.result == '0, 32'(bus.result), 32'd0);
      #1 rst = 1'b0;

      send(4'b1100, 4'b1010, 7'h7f, E_FULL, 1'b0, acc1);
      wait_done(1'b0);

      send(4'b1100, 4'b1010, 7'b0100001, E_PART, 1'b0, acc1);
      wait_done(1'b0);

      bus.out_ready = 1'b0;
      send(4'b0101, 4'b0011, 7'h7f, model(4'b0101, 4'b0011, 7'h7f),
           1'b0, acc1);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            found = 1'b1;
            break;
         end
      end
      chk("bp_valid_seen", found, 32'(found), 32'd1);
      held = bus.result;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("bp_hold", bus.out_valid && !bus.in_ready &&
             bus.result == held, 32'(bus.result), 32'(held));
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release", bus.in_ready && !bus.out_valid,
          32'({bus.in_ready, bus.out_valid}), 32'b10);
      chk("bp_popped", q.size() == 0, 32'(q.size()), 32'd0);

      send(4'b1100, 4'b1010, 7'h7f, E_FULL, 1'b0, acc1);
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            bus.a = 4'b0000;
            bus.b = 4'b1111;
            bus.op_mask = 7'b0;
         end else begin
            bus.a = 4'($urandom);
            bus.b = 4'($urandom);
            bus.op_mask = 7'($urandom);
         end
         @(posedge clk);
         #1;
      end
      wait_done(1'b0);

      send(4'b1001, 4'b0110, 7'h7f, '0, 1'b0, acc1);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.op_idx == 3'd3 && bus.busy) begin
            found = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("mid_eval_reached", found, 32'(found), 32'd1);
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_state", bus.in_ready && !bus.out_valid && !bus.busy,
          32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
      chk("mid_rst_result", bus.result == '0, 32'(bus.result), 32'd0);
      send(4'b0000, 4'b1111, 7'h7f, E_ZF, 1'b0, acc1);
      wait_done(1'b0);

      send(4'b1100, 4'b1010, 7'h7f, E_FULL, 1'b1, acc1);
      send(4'b0110, 4'b1011, 7'b1010101,
           model(4'b0110, 4'b1011, 7'b1010101), 1'b0, acc2);
      chk("b2b_spacing", acc2 - acc1 == 9, 32'(acc2 - acc1), 32'd9);
      wait_done(1'b0);

      for (int n = 0; n < 25; n++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         rm = 7'($urandom);
         send(ra, rb, rm, model(ra, rb, rm), 1'b0, acc1);
         wait_done(n % 2 == 1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      chk("queue_empty", q.size() == 0, 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
